// File: rtl/pc_unit.sv
// Program-counter unit: sequential/branch/jump/call/return next-PC selection,
// exception redirect with EPC capture, and a circular return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             flush,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_CALL = 3'd3;
  localparam logic [2:0] SEL_RET  = 3'd4;

  // Return-address storage; top points at the most recent entry. Depth is a
  // power of two so pointer arithmetic wraps naturally, and a push while full
  // lands on the oldest slot, discarding it.
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_d, epc_d, pc_seq;
  logic             flush_d, push, ovf_set, unf_set;
  logic [PTR_W-1:0] top_inc;

  assign pc_seq    = pc + STEP_W;
  assign top_inc   = top_q + 1'b1;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  // Next-state selection: exception beats stall, stall beats sel.
  always_comb begin
    pc_d    = pc;
    epc_d   = epc;
    flush_d = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    top_d   = top_q;
    cnt_d   = cnt_q;
    if (exc) begin
      pc_d    = EXC_VECTOR;
      epc_d   = pc;
      flush_d = 1'b1;
    end else if (!stall) begin
      case (sel)
        SEL_BR, SEL_JMP: begin
          pc_d    = target;
          flush_d = 1'b1;
        end
        SEL_CALL: begin
          pc_d    = target;
          flush_d = 1'b1;
          push    = 1'b1;
          top_d   = top_inc;
          if (ras_full) ovf_set = 1'b1;
          else          cnt_d   = cnt_q + 1'b1;
        end
        SEL_RET: begin
          flush_d = 1'b1;
          if (ras_empty) begin
            pc_d    = target;
            unf_set = 1'b1;
          end else begin
            pc_d  = ras_q[top_q];
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: pc_d = pc_seq;
      endcase
    end
  end

  // Architectural state with asynchronous reset; sticky flags only ever set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      epc     <= '0;
      flush   <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc    <= pc_d;
      epc   <= epc_d;
      flush <= flush_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (ovf_set) ras_ovf <= 1'b1;
      if (unf_set) ras_unf <= 1'b1;
    end
  end

  // Stack payload needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) ras_q[top_inc] <= pc_seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for the main sequences plus a
// hand-written asynchronous-reset sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [31:0] target = '0;
  logic [31:0] pc, epc;
  logic        flush, ras_empty, ras_full, ras_ovf, ras_unf;

  int nchk = 0;
  int nerr = 0;

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .exc(exc), .sel(sel), .target(target),
    .pc(pc), .epc(epc), .flush(flush), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, exc;
    logic [2:0]  sel;
    logic [31:0] target;
    logic [31:0] pc, epc;
    logic        flush, empty, full, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic e, logic [2:0] sl, logic [31:0] t,
                              logic [31:0] p, logic [31:0] ep, logic f,
                              logic em, logic fu, logic ov, logic un);
    vec_t v;
    v.stall = s; v.exc = e; v.sel = sl; v.target = t;
    v.pc = p; v.epc = ep; v.flush = f; v.empty = em; v.full = fu; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] p, logic [31:0] ep, logic f,
                         logic em, logic fu, logic ov, logic un);
    chk({tag, " pc"}, pc, p);
    chk({tag, " epc"}, epc, ep);
    chk({tag, " flush"}, 32'(flush), 32'(f));
    chk({tag, " ras_empty"}, 32'(ras_empty), 32'(em));
    chk({tag, " ras_full"}, 32'(ras_full), 32'(fu));
    chk({tag, " ras_ovf"}, 32'(ras_ovf), 32'(ov));
    chk({tag, " ras_unf"}, 32'(ras_unf), 32'(un));
  endtask

  // Drive one cycle of inputs, let the edge happen, check on the falling edge.
  task automatic apply(string tag, vec_t v);
    stall = v.stall; exc = v.exc; sel = v.sel; target = v.target;
    @(posedge clk);
    @(negedge clk);
    chk_all(tag, v.pc, v.epc, v.flush, v.empty, v.full, v.ovf, v.unf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    //              st ex sel target         pc            epc     fl em fu ov un
    // sequential from reset
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h4,        32'h0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h8,        32'h0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'hC,        32'h0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h10,       32'h0,  0, 1, 0, 0, 0));
    // call / seq / return
    vecs.push_back(mk(0, 0, 3'd3, 32'h200,      32'h200,      32'h0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h204,      32'h0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h0,        32'h14,       32'h0,  1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h18,       32'h0,  0, 1, 0, 0, 0));
    // five calls overflow the stack, then drain and underflow
    vecs.push_back(mk(0, 0, 3'd2, 32'h0,        32'h0,        32'h0,  1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h100,      32'h100,      32'h0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h200,      32'h200,      32'h0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h300,      32'h300,      32'h0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h400,      32'h400,      32'h0,  1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3'd3, 32'h500,      32'h500,      32'h0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h0,        32'h404,      32'h0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h0,        32'h304,      32'h0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h0,        32'h204,      32'h0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h0,        32'h104,      32'h0,  1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd4, 32'h999,      32'h999,      32'h0,  1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h99D,      32'h0,  0, 1, 0, 1, 1));
    // exception beats stall; stall holds; exception with sel=call does not push
    vecs.push_back(mk(0, 0, 3'd2, 32'h40,       32'h40,       32'h0,  1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 3'd0, 32'h0,        32'h80,       32'h40, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'd3, 32'h123,      32'h80,       32'h40, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'd4, 32'h0,        32'h80,       32'h40, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3'd3, 32'h300,      32'h80,       32'h80, 1, 1, 0, 1, 1));
    // branch, wrap-around, sel 5-7 behave as sequential
    vecs.push_back(mk(0, 0, 3'd1, 32'h1000,     32'h1000,     32'h80, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd2, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        32'h80, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd5, 32'h0,        32'h4,        32'h80, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd7, 32'h0,        32'h8,        32'h80, 0, 1, 0, 1, 1));

    // reset state, asserted asynchronously before any clock edge
    #1 reset = 1'b1;
    #3 chk_all("reset", 32'h0, 32'h0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

    // asynchronous reset right after a call, checked before the next edge
    apply("call700", mk(0, 0, 3'd3, 32'h700, 32'h700, 32'h80, 1, 0, 0, 1, 1));
    #2 reset = 1'b1;
    #1 chk_all("async_rst", 32'h0, 32'h0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    apply("post_rst_seq", mk(0, 0, 3'd0, 32'h0,   32'h4,   32'h0, 0, 1, 0, 0, 0));
    apply("post_rst_call", mk(0, 0, 3'd3, 32'h100, 32'h100, 32'h0, 1, 0, 0, 0, 0));
    apply("stall_ret",    mk(1, 0, 3'd4, 32'h0,   32'h100, 32'h0, 0, 0, 0, 0, 0));
    apply("ret_after",    mk(0, 0, 3'd4, 32'h0,   32'h8,   32'h0, 1, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
